rs_bank: RTL and testbench
==========================

# rs_bank

Four-entry reservation station bank in the issue/execute boundary of the OoO core, directly downstream of `rs_scheduler`. It accepts one `rs_data_t` packet per cycle into the free slot chosen by the scheduler and snoops the common data bus (CDB) to resolve pending operand tags. It dispatches the oldest fully-ready entry to the ALU through a registered valid/ready output and returns per-entry busy status to the scheduler.

## Interface
Parameters:
- `RS_ENTRIES`, 4: number of entries; fixed to match `busy_bus`/`rs_dest` widths.
- `TAG_W`, 4: ROB tag width; tag 0 means "operand ready".

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rs_dest`  in  3  slot select from scheduler; values 0–3 write that entry; `rs_dest[2]`=1 means no issue.
- `rs_input`  in  `rs_data_t`  issue packet: `Q_j`, `Q_k`, `V_j`, `V_k`, `ROB_entry`, `ALU_op`, `branch_type`, `busy`.
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_tag`  in  4  ROB tag of broadcast result.
- `cdb_value`  in  32  broadcast result.
- `flush`  in  1  mispredict recovery; discard all entries and pending dispatch.
- `ex_ready`  in  1  ALU accepts `ex_packet` this cycle.
- `busy_bus`  out  4  registered per-entry busy flags.
- `ex_valid`  out  1  `ex_packet` holds a dispatched operation.
- `ex_packet`  out  `rs_exec_t`  `V_j`, `V_k`, `ALU_op`, `branch_type`, `ROB_entry`.

## Operation
- Entry state: `busy`, `Q_j`, `Q_k`, `V_j`, `V_k`, `ALU_op`, `branch_type`, `ROB_entry`.
- Issue: when `rs_dest[2]`=0, entry `rs_dest[1:0]` is loaded and `busy` is set. The scheduler guarantees that the slot is not busy. A write to a busy slot is a protocol error; the bench flags it with an assertion.
- Issue-cycle bypass: if `cdb_valid` is high, `cdb_tag`≠0 and `cdb_tag` equals incoming `Q_j` (or `Q_k`), store `cdb_value` into that operand and clear its tag.
- Wakeup: for every busy entry whose `Q_j`/`Q_k` equals a valid nonzero `cdb_tag`, latch `cdb_value` and clear the tag. `cdb_valid` with tag 0 is ignored.
- Ready: `busy && Q_j==0 && Q_k==0`, evaluated on registered state only. An entry woken this cycle becomes ready next cycle.
- Select: among ready entries, pick the oldest by age matrix. On allocation of entry i, set `older[j][i]`=1 for every busy j and clear row i.
- Dispatch: when the output register is empty or `ex_ready`=1, the selected entry is copied to `ex_packet`, `ex_valid` is set, and the entry's `busy` clears at the same edge. If nothing is ready and `ex_ready`=1, `ex_valid` clears.
- Output hold: while `ex_valid`=1 and `ex_ready`=0, `ex_packet` is stable and no entry dispatches.
- A slot freed at edge E may be reissued by the scheduler in the cycle after E (it sees `busy_bus` updated).
- Flush has priority over issue, wakeup and dispatch: all `busy` flags clear, `ex_valid` clears, and the age matrix clears.

## Timing
- Reset (`rst_n`=0 at edge): `busy_bus`=4'b0000, `ex_valid`=0, `ex_packet`='0, all entry fields and age matrix '0.
- Issue-to-dispatch latency, operands ready: packet written at edge E0, `ex_valid`=1 after E1 (2 edges).
- Wakeup-to-dispatch: CDB match at edge E0, `ex_valid` after E1.
- Throughput: one dispatch per cycle while `ex_ready`=1.
- Simultaneous issue and dispatch to different slots: both occur. Issue into a slot freed at the same edge cannot happen, because `busy_bus` is registered.
- Reset or flush mid-backpressure: the output is dropped and no ALU handshake is owed.

## Structure
- Add `rs_exec_t` and `RS_ENTRIES` to `structs.svh`, alongside `rs_data_t`.
- Sub-module `rs_age_matrix`: 4×4 older bits. Inputs: alloc one-hot, free one-hot, ready vector, flush. Output: one-hot oldest-ready grant.
- The remaining logic (entry storage, CDB compare, output register) stays in `rs_bank`.

## Test plan
- Reset, then issue ADD to slot 0 (`Q_j`=`Q_k`=0, `V_j`=5, `V_k`=7, `ALU_op`=000) with `ex_ready`=1 → `ex_valid` after 2nd edge, `V_j`=5, `V_k`=7; `busy_bus`=0001 then 0000.
- Issue to slot 1 with `Q_j`=3; CDB tag 3, value 0x1234 two cycles later → `V_j`=0x1234, dispatched one edge after broadcast.
- Issue with `Q_k`=5 in the same cycle as CDB tag 5, value 9 → entry stored with `Q_k`=0, `V_k`=9, dispatched next edge.
- Fill slots 2, 0, 3 in that order with tags pending, then wake all in one CDB cycle (same tag 6) → dispatch order 2, 0, 3 on consecutive edges.
- Hold `ex_ready`=0 with two ready entries → `ex_packet` stable and `busy_bus` unchanged; release → two dispatches on successive edges.
- Three busy entries plus `ex_valid`=1, assert `flush` together with an issue to slot 3 → next cycle `busy_bus`=0000, `ex_valid`=0.

Source files
------------

// File: rtl/rs_bank_pkg.sv
// Shared widths, payload structs and CDB compare helper for the reservation station bank.
package rs_bank_pkg;

    localparam int unsigned RS_ENTRIES = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned TAG_W      = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned OP_W       = 3;
    localparam int unsigned BR_W       = 3;

    typedef struct packed {
        logic              busy;
        logic [TAG_W-1:0]  q_j;
        logic [TAG_W-1:0]  q_k;
        logic [DATA_W-1:0] v_j;
        logic [DATA_W-1:0] v_k;
        logic [TAG_W-1:0]  rob_entry;
        logic [OP_W-1:0]   alu_op;
        logic [BR_W-1:0]   branch_type;
    } rs_data_t;

    typedef struct packed {
        logic [DATA_W-1:0] v_j;
        logic [DATA_W-1:0] v_k;
        logic [OP_W-1:0]   alu_op;
        logic [BR_W-1:0]   branch_type;
        logic [TAG_W-1:0]  rob_entry;
    } rs_exec_t;

    // Tag 0 marks a ready operand, so a zero broadcast never matches.
    function automatic logic cdb_hit(input logic             valid,
                                     input logic [TAG_W-1:0] bus_tag,
                                     input logic [TAG_W-1:0] q);
        return valid && (bus_tag != '0) && (q == bus_tag);
    endfunction

    function automatic rs_exec_t to_exec(input rs_data_t e);
        rs_exec_t x;
        x.v_j         = e.v_j;
        x.v_k         = e.v_k;
        x.alu_op      = e.alu_op;
        x.branch_type = e.branch_type;
        x.rob_entry   = e.rob_entry;
        return x;
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: older[j][i]=1 means entry j was allocated before entry i; grants the oldest ready entry.
module rs_age_matrix
    import rs_bank_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RS_ENTRIES-1:0] alloc,
    input  logic [RS_ENTRIES-1:0] free,
    input  logic [RS_ENTRIES-1:0] ready,
    input  logic                  flush,
    output logic [RS_ENTRIES-1:0] grant_c
);

    logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] older_q, older_d;
    logic [RS_ENTRIES-1:0]                 valid_q, valid_d;
    logic [RS_ENTRIES-1:0]                 blocked;

    // Next matrix: a new entry is younger than every entry still live after this edge.
    always_comb begin
        older_d = older_q;
        valid_d = valid_q;
        if (flush) begin
            older_d = '0;
            valid_d = '0;
        end else begin
            for (int i = 0; i < int'(RS_ENTRIES); i++) begin
                if (free[i]) older_d[i] = '0;
            end
            for (int i = 0; i < int'(RS_ENTRIES); i++) begin
                if (alloc[i]) begin
                    older_d[i] = '0;
                    for (int j = 0; j < int'(RS_ENTRIES); j++) begin
                        if (j != i) older_d[j][i] = valid_q[j] & ~free[j];
                    end
                end
            end
            valid_d = (valid_q & ~free) | alloc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            older_q <= '0;
            valid_q <= '0;
        end else begin
            older_q <= older_d;
            valid_q <= valid_d;
        end
    end

    // An entry wins when no older entry is also ready.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < int'(RS_ENTRIES); i++) begin
            for (int j = 0; j < int'(RS_ENTRIES); j++) begin
                if (ready[j] && older_q[j][i]) blocked[i] = 1'b1;
            end
        end
        grant_c = ready & ~blocked;
    end

endmodule

// File: rtl/rs_bank.sv
// Four-entry reservation station: issue with CDB bypass, tag wakeup, oldest-ready dispatch to a registered ALU port.
module rs_bank
    import rs_bank_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            rs_dest,
    input  rs_data_t              rs_input,
    input  logic                  cdb_valid,
    input  logic [TAG_W-1:0]      cdb_tag,
    input  logic [DATA_W-1:0]     cdb_value,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic [RS_ENTRIES-1:0] busy_bus,
    output logic                  ex_valid,
    output rs_exec_t              ex_packet
);

    rs_data_t              entry_q [RS_ENTRIES];
    rs_data_t              entry_d [RS_ENTRIES];
    logic [RS_ENTRIES-1:0] ready;
    logic [RS_ENTRIES-1:0] grant_c;
    logic [RS_ENTRIES-1:0] alloc;
    logic [RS_ENTRIES-1:0] free;
    logic                  issue;
    logic                  dispatch_en;
    logic                  fire;
    rs_exec_t              sel_packet;

    assign issue       = ~rs_dest[2];
    assign dispatch_en = ~ex_valid | ex_ready;
    assign fire        = dispatch_en & ~flush & (|grant_c);
    assign alloc       = issue ? (RS_ENTRIES'(1) << rs_dest[1:0]) : '0;
    assign free        = fire ? grant_c : '0;

    always_comb begin
        for (int i = 0; i < int'(RS_ENTRIES); i++) begin
            ready[i]    = entry_q[i].busy && (entry_q[i].q_j == '0) && (entry_q[i].q_k == '0);
            busy_bus[i] = entry_q[i].busy;
        end
    end

    // Entry update; flush outranks issue, wakeup and dispatch.
    always_comb begin
        for (int i = 0; i < int'(RS_ENTRIES); i++) begin
            entry_d[i] = entry_q[i];
            if (flush) begin
                entry_d[i].busy = 1'b0;
            end else if (issue && (rs_dest[1:0] == IDX_W'(i))) begin
                entry_d[i]      = rs_input;
                entry_d[i].busy = 1'b1;
                if (cdb_hit(cdb_valid, cdb_tag, rs_input.q_j)) begin
                    entry_d[i].v_j = cdb_value;
                    entry_d[i].q_j = '0;
                end
                if (cdb_hit(cdb_valid, cdb_tag, rs_input.q_k)) begin
                    entry_d[i].v_k = cdb_value;
                    entry_d[i].q_k = '0;
                end
            end else begin
                if (free[i]) entry_d[i].busy = 1'b0;
                if (entry_q[i].busy && cdb_hit(cdb_valid, cdb_tag, entry_q[i].q_j)) begin
                    entry_d[i].v_j = cdb_value;
                    entry_d[i].q_j = '0;
                end
                if (entry_q[i].busy && cdb_hit(cdb_valid, cdb_tag, entry_q[i].q_k)) begin
                    entry_d[i].v_k = cdb_value;
                    entry_d[i].q_k = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(RS_ENTRIES); i++) begin
            if (!rst_n) entry_q[i] <= '0;
            else        entry_q[i] <= entry_d[i];
        end
    end

    // Grant is one-hot, so a plain priority loop acts as the select mux.
    always_comb begin
        sel_packet = '0;
        for (int i = 0; i < int'(RS_ENTRIES); i++) begin
            if (grant_c[i]) sel_packet = to_exec(entry_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_packet <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (dispatch_en) begin
            ex_valid <= |grant_c;
            if (|grant_c) ex_packet <= sel_packet;
        end
    end

    rs_age_matrix u_age (
        .clk     (clk),
        .rst_n   (rst_n),
        .alloc   (alloc),
        .free    (free),
        .ready   (ready),
        .flush   (flush),
        .grant_c (grant_c)
    );

endmodule

// File: tb/tb_rs_bank.sv
// Directed plus random bench for rs_bank against an allocation-stamp reference model.
module tb_rs_bank;
    import rs_bank_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic [2:0]            rs_dest;
    rs_data_t              rs_input;
    logic                  cdb_valid;
    logic [TAG_W-1:0]      cdb_tag;
    logic [DATA_W-1:0]     cdb_value;
    logic                  flush;
    logic                  ex_ready;
    logic [RS_ENTRIES-1:0] busy_bus;
    logic                  ex_valid;
    rs_exec_t              ex_packet;

    int checks   = 0;
    int failures = 0;

    // Reference model: each live entry carries the sequence number of its issue.
    logic              m_busy [4];
    logic [TAG_W-1:0]  m_qj   [4];
    logic [TAG_W-1:0]  m_qk   [4];
    logic [DATA_W-1:0] m_vj   [4];
    logic [DATA_W-1:0] m_vk   [4];
    logic [TAG_W-1:0]  m_rob  [4];
    logic [OP_W-1:0]   m_op   [4];
    logic [BR_W-1:0]   m_br   [4];
    int                m_seq  [4];
    int                seq_ctr = 0;
    logic              m_exv;
    rs_exec_t          m_exp;

    rs_bank dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_dest   (rs_dest),
        .rs_input  (rs_input),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .flush     (flush),
        .ex_ready  (ex_ready),
        .busy_bus  (busy_bus),
        .ex_valid  (ex_valid),
        .ex_packet (ex_packet)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic hit(input logic [TAG_W-1:0] q);
        return cdb_valid && (cdb_tag != 0) && (q == cdb_tag);
    endfunction

    function automatic logic [3:0] m_busy_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Advance model by one edge from current inputs, clock DUT, then compare.
    task automatic step();
        int   sel;
        int   d;
        logic den;
        if (rst_n && !flush && !rs_dest[2])
            chk("proto_free_slot", 128'(busy_bus[rs_dest[1:0]]), 128'(1'b0));
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_busy[i] = 0; m_qj[i] = 0; m_qk[i] = 0; m_vj[i] = 0; m_vk[i] = 0;
                m_rob[i] = 0; m_op[i] = 0; m_br[i] = 0; m_seq[i] = 0;
            end
            m_exv = 0;
            m_exp = '0;
        end else if (flush) begin
            for (int i = 0; i < 4; i++) m_busy[i] = 0;
            m_exv = 0;
        end else begin
            den = !m_exv || ex_ready;
            sel = -1;
            for (int i = 0; i < 4; i++) begin
                if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0 &&
                    (sel < 0 || m_seq[i] < m_seq[sel])) sel = i;
            end
            if (den) begin
                if (sel >= 0) begin
                    m_exv             = 1;
                    m_exp.v_j         = m_vj[sel];
                    m_exp.v_k         = m_vk[sel];
                    m_exp.alu_op      = m_op[sel];
                    m_exp.branch_type = m_br[sel];
                    m_exp.rob_entry   = m_rob[sel];
                    m_busy[sel]       = 0;
                end else begin
                    m_exv = 0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (m_busy[i] && hit(m_qj[i])) begin m_vj[i] = cdb_value; m_qj[i] = 0; end
                if (m_busy[i] && hit(m_qk[i])) begin m_vk[i] = cdb_value; m_qk[i] = 0; end
            end
            if (!rs_dest[2]) begin
                d = int'(rs_dest[1:0]);
                m_busy[d] = 1;
                m_qj[d] = rs_input.q_j; m_qk[d] = rs_input.q_k;
                m_vj[d] = rs_input.v_j; m_vk[d] = rs_input.v_k;
                m_rob[d] = rs_input.rob_entry; m_op[d] = rs_input.alu_op; m_br[d] = rs_input.branch_type;
                if (hit(rs_input.q_j)) begin m_vj[d] = cdb_value; m_qj[d] = 0; end
                if (hit(rs_input.q_k)) begin m_vk[d] = cdb_value; m_qk[d] = 0; end
                m_seq[d] = seq_ctr;
                seq_ctr++;
            end
        end
        @(posedge clk);
        #1;
        chk("model_busy_bus", 128'(busy_bus), 128'(m_busy_vec()));
        chk("model_ex_valid", 128'(ex_valid), 128'(m_exv));
        if (m_exv) chk("model_ex_packet", 128'(ex_packet), 128'(m_exp));
    endtask

    task automatic idle();
        rs_dest   = 3'b100;
        rs_input  = '0;
        cdb_valid = 0;
        cdb_tag   = 0;
        cdb_value = 0;
        flush     = 0;
    endtask

    task automatic put(input int slot, input int qj, input int qk, input int vj, input int vk, input int rob);
        rs_dest              = {1'b0, 2'(slot)};
        rs_input             = '0;
        rs_input.q_j         = 4'(qj);
        rs_input.q_k         = 4'(qk);
        rs_input.v_j         = 32'(vj);
        rs_input.v_k         = 32'(vk);
        rs_input.rob_entry   = 4'(rob);
        rs_input.alu_op      = 3'(rob);
        rs_input.branch_type = 3'(slot);
    endtask

    task automatic bcast(input int tag, input int val);
        cdb_valid = 1;
        cdb_tag   = 4'(tag);
        cdb_value = 32'(val);
    endtask

    initial begin
        int free_n;
        int free_list [4];
        idle();
        ex_ready = 1;
        rst_n    = 0;
        step();
        step();
        chk("reset_busy_bus", 128'(busy_bus), 128'(4'b0000));
        chk("reset_ex_valid", 128'(ex_valid), 128'(1'b0));
        chk("reset_ex_packet", 128'(ex_packet), 128'(0));
        rst_n = 1;

        // Ready ADD: two edges to dispatch.
        put(0, 0, 0, 5, 7, 1); step(); idle();
        chk("add_busy_after_issue", 128'(busy_bus), 128'(4'b0001));
        chk("add_not_yet_valid", 128'(ex_valid), 128'(1'b0));
        step();
        chk("add_ex_valid", 128'(ex_valid), 128'(1'b1));
        chk("add_v_j", 128'(ex_packet.v_j), 128'(32'd5));
        chk("add_v_k", 128'(ex_packet.v_k), 128'(32'd7));
        chk("add_busy_freed", 128'(busy_bus), 128'(4'b0000));

        // Wakeup of pending Q_j two cycles after issue.
        put(1, 3, 0, 0, 11, 2); step(); idle();
        step();
        bcast(3, 32'h1234); step(); idle();
        chk("wake_not_yet", 128'(ex_valid), 128'(1'b0));
        step();
        chk("wake_ex_valid", 128'(ex_valid), 128'(1'b1));
        chk("wake_v_j", 128'(ex_packet.v_j), 128'(32'h1234));

        // Issue-cycle bypass on Q_k.
        put(2, 0, 5, 4, 0, 3); bcast(5, 9); step(); idle();
        chk("bypass_busy", 128'(busy_bus), 128'(4'b0100));
        step();
        chk("bypass_v_k", 128'(ex_packet.v_k), 128'(32'd9));
        chk("bypass_rob", 128'(ex_packet.rob_entry), 128'(4'd3));

        // Age order 2, 0, 3 after a common wakeup.
        put(2, 6, 0, 0, 1, 4); step();
        put(0, 6, 0, 0, 2, 5); step();
        put(3, 6, 0, 0, 3, 6); step(); idle();
        bcast(6, 77); step(); idle();
        step(); chk("age_first", 128'(ex_packet.rob_entry), 128'(4'd4));
        step(); chk("age_second", 128'(ex_packet.rob_entry), 128'(4'd5));
        step(); chk("age_third", 128'(ex_packet.rob_entry), 128'(4'd6));
        step();

        // Backpressure hold.
        ex_ready = 0;
        put(0, 0, 0, 1, 1, 7); step();
        put(1, 0, 0, 2, 2, 8); step();
        put(2, 0, 0, 3, 3, 9); step(); idle();
        step();
        chk("hold_rob", 128'(ex_packet.rob_entry), 128'(4'd7));
        chk("hold_busy", 128'(busy_bus), 128'(4'b0110));
        step();
        chk("hold_rob_again", 128'(ex_packet.rob_entry), 128'(4'd7));
        ex_ready = 1;
        step(); chk("release_first", 128'(ex_packet.rob_entry), 128'(4'd8));
        step(); chk("release_second", 128'(ex_packet.rob_entry), 128'(4'd9));
        step();

        // Flush beats a simultaneous issue.
        ex_ready = 0;
        put(0, 0, 0, 1, 1, 10); step();
        put(1, 9, 0, 0, 0, 11); step();
        put(0, 9, 0, 0, 0, 12); step();
        put(2, 9, 0, 0, 0, 13); step();
        chk("preflush_busy", 128'(busy_bus), 128'(4'b0111));
        chk("preflush_valid", 128'(ex_valid), 128'(1'b1));
        put(3, 0, 0, 1, 1, 14); flush = 1; step(); idle();
        chk("flush_busy", 128'(busy_bus), 128'(4'b0000));
        chk("flush_valid", 128'(ex_valid), 128'(1'b0));
        ex_ready = 1;
        step();

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            idle();
            ex_ready = ($urandom % 4) != 0;
            flush    = ($urandom % 50) == 0;
            free_n = 0;
            for (int i = 0; i < 4; i++) if (!m_busy[i]) begin free_list[free_n] = i; free_n++; end
            if (free_n > 0 && ($urandom % 2) == 1) begin
                put(free_list[$urandom % free_n],
                    (($urandom % 3) == 0) ? $urandom_range(1, 7) : 0,
                    (($urandom % 3) == 0) ? $urandom_range(1, 7) : 0,
                    int'($urandom), int'($urandom), $urandom_range(0, 15));
                rs_input.alu_op      = 3'($urandom);
                rs_input.branch_type = 3'($urandom);
            end
            if (($urandom % 2) == 1) bcast($urandom_range(0, 7), int'($urandom));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
